tpram_fifo_ctrl: RTL and testbench
==================================

TPRAM_FIFO_CTRL -- requirements
Module: tpram_fifo_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock; also drives RAM RCLK/WCLK
- rst  in  1  synchronous active-high reset
- in_valid  in  1  write request
- in_ready  out  1  write accepted when in_valid & in_ready
- in_data  in  144  write word
- out_valid  out  1  head word available
- out_ready  in  1  consumer pop; pop = out_valid & out_ready
- out_data  out  144  head word
- count  out  7  words held (RAM + in-flight + output buffer), 0..66
- ram_rceb  out  1  RAM read enable, active-low
- ram_raddr  out  6  RAM read address
- ram_rdata  in  144  RAM read data, valid one cycle after ram_rceb low
- ram_wceb  out  1  RAM write enable, active-low
- ram_waddr  out  6  RAM write address
- ram_wdata  out  144  RAM write data

Function
REQ-003 SHALL control one 64x144 two-port RAM as a FIFO: wr_ptr, rd_ptr 6-bit, wrap 63->0 naturally; ram_cnt 0..64.
REQ-004 SHALL drive ram_wceb = ~(in_valid & in_ready), ram_waddr = wr_ptr, ram_wdata = in_data (combinational); on write, wr_ptr+1, ram_cnt+1.
REQ-005 SHALL hold a 2-entry output buffer (obuf_cnt 0..2) plus 1-bit inflight flag.
REQ-006 SHALL issue read (rd_issue) when ram_cnt>0 and obuf_cnt + inflight - pop < 2; rd_issue depends not on in_valid.
REQ-007 SHALL drive ram_rceb = ~rd_issue, ram_raddr = rd_ptr; on issue, rd_ptr+1, ram_cnt-1, inflight set next cycle.
REQ-008 SHALL capture ram_rdata into obuf on the edge after an inflight cycle; order preserved.
REQ-009 SHALL present obuf head on out_data; out_valid = (obuf_cnt>0); out_data don't-care when out_valid=0.
REQ-010 SHALL sustain one write and one pop per cycle in steady state (with REQ-019 macro defined).
REQ-011 SHALL assert first out_valid two edges after the acceptance edge of a word into an empty FIFO.
REQ-012 SHALL compute in_ready = (ram_cnt < 64) [&& per REQ-020]; write when ram_cnt=64 impossible.
REQ-013 SHALL update ram_cnt correctly on simultaneous write and read-issue (net 0).
REQ-014 SHALL never read an unwritten address: read address never equals the same-cycle write address.
REQ-015 SHALL drive count = ram_cnt + inflight + obuf_cnt, registered, exact every cycle.
REQ-016 SHALL hold out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-017 SHALL on rst: wr_ptr=rd_ptr=0, ram_cnt=0, obuf_cnt=0, inflight=0, count=0, out_valid=0, ram_rceb=1, ram_wceb=1, in_ready=0 during rst.
REQ-018 SHALL discard in-flight RAM read data when rst asserts mid-operation; RAM contents not cleared.

Configuration
REQ-019 SHALL use macro TPRAM_DUAL_ACCESS_EN: defined -> read and write may both enable in one cycle (true two-port RAM).
REQ-020 SHALL, without TPRAM_DUAL_ACCESS_EN, allow at most one RAM access per cycle (RAM shares one address): read priority, in_ready = (ram_cnt<64) & ~rd_issue; write throughput then reduced, no data loss.

Verification
REQ-021 Bench SHALL cover: write 0x1 at reset exit, out_ready=1 -> out_valid high 2 edges later, out_data=0x1, count 1->0 after pop.
REQ-022 Bench SHALL cover: 66 writes with out_ready=0 -> in_ready=0 after 66th, count=66, ram_cnt=64; then 66 pops return 0..65 in order.
REQ-023 Bench SHALL cover: macro defined, 200 words back-to-back with out_ready=1 -> one pop per cycle after fill, no bubble, data ordered.
REQ-024 Bench SHALL cover: macro undefined, same stream -> ram_rceb and ram_wceb never both 0 in one cycle, all 200 words correct.
REQ-025 Bench SHALL cover: rst pulsed with inflight=1 and count=5 -> next cycle count=0, out_valid=0; new write 0xA5 emerges first.
REQ-026 Bench SHALL cover: random out_ready at 30% and in_valid at 70%, 10000 words -> scoreboard match, wrap of both pointers exercised.

Source files
------------

// File: rtl/tpram_fifo_ctrl.sv
// tpram_fifo_ctrl
// FIFO controller wrapped around an external 64x144 two-port RAM. A 2-entry
// output buffer plus an in-flight flag hides the RAM's one-cycle read latency,
// so the head word is always held in flops and out_data never depends on the
// RAM's read port directly.
//
// Build option: macro TPRAM_DUAL_ACCESS_EN
//   defined   - a read and a write may both reach the RAM in the same cycle.
//   undefined - at most one RAM access per cycle. Reads win, and a write is
//               held off (in_ready low) in any cycle that issues a read.
module tpram_fifo_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [143:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [143:0] out_data,
   output logic [6:0]   count,
   output logic         ram_rceb,
   output logic [5:0]   ram_raddr,
   input  logic [143:0] ram_rdata,
   output logic         ram_wceb,
   output logic [5:0]   ram_waddr,
   output logic [143:0] ram_wdata
);
   localparam int         DW    = 144;
   localparam int         AW    = 6;
   localparam logic [6:0] DEPTH = 7'd64;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [6:0]    ram_cnt_reg;
   logic [6:0]    ram_cnt_next;
   logic [1:0]    obuf_cnt_reg;
   logic [1:0]    obuf_cnt_next;
   logic          inflight_reg;
   logic [6:0]    count_reg;
   logic [6:0]    count_next;
   logic [DW-1:0] obuf_reg [2];

   logic       pop;
   logic       rd_issue;
   logic       wr_en;
   logic       space_ok;
   logic [2:0] occ;
   logic [2:0] occ_limit;
   logic       cap_slot;

   assign pop       = out_valid & out_ready;
   assign out_valid = (obuf_cnt_reg != 2'd0);
   assign out_data  = obuf_reg[0];
   assign count     = count_reg;

   // A read may only be launched if its data is guaranteed a buffer slot:
   // words already buffered plus the one in flight, less this cycle's pop,
   // must stay below 2. Written as occ < 2 + pop to avoid an underflow.
   assign occ       = {1'b0, obuf_cnt_reg} + {2'b00, inflight_reg};
   assign occ_limit = 3'd2 + {2'b00, pop};
   assign rd_issue  = ~rst & (ram_cnt_reg != 7'd0) & (occ < occ_limit);

   assign space_ok  = ~rst & (ram_cnt_reg < DEPTH);
`ifdef TPRAM_DUAL_ACCESS_EN
   assign in_ready  = space_ok;
`else
   assign in_ready  = space_ok & ~rd_issue;
`endif
   assign wr_en     = in_valid & in_ready;

   // Since ram_cnt is in 1..63 whenever both ports are active, rd_ptr can
   // never equal wr_ptr in a cycle that reads and writes together.
   assign ram_rceb  = ~rd_issue;
   assign ram_raddr = rd_ptr_reg;
   assign ram_wceb  = ~wr_en;
   assign ram_waddr = wr_ptr_reg;
   assign ram_wdata = in_data;

   // Next-state occupancy; count is the sum of what every stage will hold.
   // The landing slot for returning read data is obuf_cnt - pop, which is
   // always 0 or 1, so its low bit alone selects the slot.
   always_comb begin
      ram_cnt_next  = ram_cnt_reg + {6'd0, wr_en} - {6'd0, rd_issue};
      obuf_cnt_next = obuf_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
      count_next    = ram_cnt_next + {5'd0, obuf_cnt_next} + {6'd0, rd_issue};
      cap_slot      = obuf_cnt_reg[0] ^ pop;
   end

   // Pointers, occupancy counters and the registered word count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         ram_cnt_reg  <= '0;
         obuf_cnt_reg <= '0;
         inflight_reg <= 1'b0;
         count_reg    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 6'd1;
         end
         if (rd_issue) begin
            rd_ptr_reg <= rd_ptr_reg + 6'd1;
         end
         ram_cnt_reg  <= ram_cnt_next;
         obuf_cnt_reg <= obuf_cnt_next;
         inflight_reg <= rd_issue;
         count_reg    <= count_next;
      end
   end

   // Output buffer data: shift on pop, then land returning RAM data behind
   // whatever remains; the later assignment wins when both hit slot 0.
   always_ff @(posedge clk) begin
      if (pop) begin
         obuf_reg[0] <= obuf_reg[1];
      end
      if (inflight_reg & ~rst) begin
         obuf_reg[cap_slot] <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_tpram_fifo_ctrl.sv
// tb_tpram_fifo_ctrl
// Directed bench for tpram_fifo_ctrl with a behavioural 64x144 RAM model.
// Honours macro TPRAM_DUAL_ACCESS_EN for the access-mode specific checks.
`timescale 1ns/1ps
module tb_tpram_fifo_ctrl;
`ifdef TPRAM_DUAL_ACCESS_EN
   localparam logic DUAL = 1'b1;
`else
   localparam logic DUAL = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [143:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [143:0] out_data;
   logic [6:0]   count;
   logic         ram_rceb;
   logic [5:0]   ram_raddr;
   logic [143:0] ram_rdata = '0;
   logic         ram_wceb;
   logic [5:0]   ram_waddr;
   logic [143:0] ram_wdata;

   int checks   = 0;
   int failures = 0;

   // scoreboard / monitor state
   logic [143:0] q[$];
   int cyc = 0;
   int npop = 0;
   int nacc = 0;
   int first_pop = -1;
   int last_pop = -1;
   int first_acc = -1;
   int last_acc = -1;
   int both_en = 0;
   int clash = 0;
   int rd_wrap = 0;
   int wr_wrap = 0;

   logic [143:0] ram_mem [64];

   always #5 clk = ~clk;

   tpram_fifo_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .ram_rceb  (ram_rceb),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .ram_wceb  (ram_wceb),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata)
   );

   // RAM model: synchronous write, registered read (data valid next cycle)
   always @(posedge clk) begin
      if (!ram_wceb) ram_mem[ram_waddr] <= ram_wdata;
      if (!ram_rceb) ram_rdata <= ram_mem[ram_raddr];
   end

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [143:0] mk(input int i);
      logic [31:0] u;
      u = i;
      return {16'h5A00 ^ u[15:0], u * 32'h9E3779B1, u ^ 32'hDEADBEEF, u + 32'h01234567, u};
   endfunction

   // Monitor: exact count every cycle, in-order data on every pop, RAM port rules
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
      end else begin
         if (!ram_rceb && !ram_wceb) begin
            both_en++;
            if (ram_raddr == ram_waddr) clash++;
         end
         if (!ram_rceb && ram_raddr == 6'd63) rd_wrap++;
         if (!ram_wceb && ram_waddr == 6'd63) wr_wrap++;
         chk("count", 144'(count), 144'(q.size()));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("pop_nonempty", 144'(q.size()), 144'd1);
            end else begin
               chk("out_data", out_data, q[0]);
               void'(q.pop_front());
            end
            npop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            nacc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic push_word(input logic [143:0] d);
      logic done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("push_accept", 144'(done), 144'd1);
   endtask

   task automatic drain(input int budget);
      logic done;
      done = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = (count == 7'd0) && !out_valid;
         @(posedge clk); #1;
      end
      chk("drain_empty", 144'(done), 144'd1);
   endtask

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       rd;     // a read issues this cycle: in_ready then equals DUAL
      logic       ov;
      logic [7:0] od;
      logic [6:0] cnt;
   } vec_t;

   function automatic vec_t v(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic rd, input logic ov, input logic [7:0] od,
                              input logic [6:0] cnt);
      vec_t r;
      r.iv = iv; r.d = d; r.ordy = ordy; r.rd = rd; r.ov = ov; r.od = od; r.cnt = cnt;
      return r;
   endfunction

   vec_t tbl [14];

   initial begin
      int npop0;
      int sent;
      logic got;

      // single word 0x1 at reset exit, consumer ready
      tbl[0]  = v(1, 8'h01, 1, 0, 0, 8'h00, 7'd0);
      tbl[1]  = v(0, 8'h00, 1, 1, 0, 8'h00, 7'd1);
      tbl[2]  = v(0, 8'h00, 1, 0, 0, 8'h00, 7'd1);
      tbl[3]  = v(0, 8'h00, 1, 0, 1, 8'h01, 7'd1);
      tbl[4]  = v(0, 8'h00, 1, 0, 0, 8'h00, 7'd0);
      // two words, consumer stalled then popping; head must stay stable
      tbl[5]  = v(1, 8'h02, 0, 0, 0, 8'h00, 7'd0);
      tbl[6]  = v(0, 8'h00, 0, 1, 0, 8'h00, 7'd1);
      tbl[7]  = v(1, 8'h03, 0, 0, 0, 8'h00, 7'd1);
      tbl[8]  = v(0, 8'h00, 0, 1, 1, 8'h02, 7'd2);
      tbl[9]  = v(0, 8'h00, 0, 0, 1, 8'h02, 7'd2);
      tbl[10] = v(0, 8'h00, 0, 0, 1, 8'h02, 7'd2);
      tbl[11] = v(0, 8'h00, 1, 0, 1, 8'h02, 7'd2);
      tbl[12] = v(0, 8'h00, 1, 0, 1, 8'h03, 7'd1);
      tbl[13] = v(0, 8'h00, 1, 0, 0, 8'h00, 7'd0);

      rst = 1'b1; in_valid = 1'b1; in_data = 144'h1; out_ready = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 144'(in_ready), 144'd0);
      chk("rst_rceb", 144'(ram_rceb), 144'd1);
      chk("rst_wceb", 144'(ram_wceb), 144'd1);
      chk("rst_count", 144'(count), 144'd0);
      chk("rst_out_valid", 144'(out_valid), 144'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         in_valid  = tbl[i].iv;
         in_data   = {136'd0, tbl[i].d};
         out_ready = tbl[i].ordy;
         @(negedge clk);
         $display("vec %0d iv=%0d d=%0h ordy=%0d -> in_ready=%0d out_valid=%0d out_data=%0h count=%0d",
                  i, in_valid, tbl[i].d, out_ready, in_ready, out_valid, out_data[7:0], count);
         chk($sformatf("vec%0d_in_ready", i), 144'(in_ready), 144'(tbl[i].rd ? DUAL : 1'b1));
         chk($sformatf("vec%0d_out_valid", i), 144'(out_valid), 144'(tbl[i].ov));
         chk($sformatf("vec%0d_count", i), 144'(count), 144'(tbl[i].cnt));
         if (tbl[i].ov) chk($sformatf("vec%0d_out_data", i), out_data, {136'd0, tbl[i].od});
         @(posedge clk); #1;
      end

      // fill to capacity with the consumer stalled, then drain in order
      out_ready = 1'b0;
      for (int k = 0; k < 66; k++) push_word(144'(k));
      in_valid = 1'b1;
      in_data  = 144'd66;
      @(negedge clk);
      chk("full_in_ready", 144'(in_ready), 144'd0);
      chk("full_count", 144'(count), 144'd66);
      chk("full_ram_cnt", 144'(dut.ram_cnt_reg), 144'd64);
      @(posedge clk); #1;
      npop0 = npop;
      drain(300);
      chk("full_pops", 144'(npop - npop0), 144'd66);
      $display("phase fill66 done: pops=%0d", npop - npop0);

      // 200-word back-to-back stream with consumer always ready
      first_pop = -1; first_acc = -1;
      npop0 = npop;
      out_ready = 1'b1;
      for (int k = 0; k < 200; k++) push_word(mk(k));
      drain(100);
      chk("stream_pops", 144'(npop - npop0), 144'd200);
`ifdef TPRAM_DUAL_ACCESS_EN
      chk("stream_acc_span", 144'(last_acc - first_acc), 144'd199);
      chk("stream_pop_span", 144'(last_pop - first_pop), 144'd199);
`endif
      $display("phase stream200 done: acc_span=%0d pop_span=%0d", last_acc - first_acc, last_pop - first_pop);

      // reset while a read is in flight
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) push_word(144'(16 + k));
      repeat (6) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_inflight", 144'(dut.inflight_reg), 144'd1);
      chk("pre_rst_count", 144'(count), 144'd5);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_count", 144'(count), 144'd0);
      chk("post_rst_out_valid", 144'(out_valid), 144'd0);
      @(posedge clk); #1;
      push_word(144'hA5);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = out_valid;
         @(posedge clk); #1;
      end
      chk("a5_valid", 144'(got), 144'd1);
      chk("a5_data", out_data, 144'hA5);
      drain(20);
      $display("phase reset_inflight done");

      // random traffic: 70% in_valid, 30% out_ready, 10000 words
      sent = 0;
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
         in_valid  = ($urandom_range(99) < 70);
         in_data   = mk(1000 + sent);
         out_ready = ($urandom_range(99) < 30);
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      chk("rand_sent", 144'(sent), 144'd10000);
      drain(400);
      chk("sb_empty", 144'(q.size()), 144'd0);
      chk("rd_ptr_wrap", 144'(rd_wrap > 100), 144'd1);
      chk("wr_ptr_wrap", 144'(wr_wrap > 100), 144'd1);
      $display("phase random done: sent=%0d rd_wrap=%0d wr_wrap=%0d", sent, rd_wrap, wr_wrap);

`ifdef TPRAM_DUAL_ACCESS_EN
      chk("addr_clash", 144'(clash), 144'd0);
`else
      chk("single_access", 144'(both_en), 144'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
